n64_poll_sched: RTL and testbench



---
 rtl/n64_poll_sched.sv | 170 +++++++++++++++++
 tb/tb_n64_poll_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_poll_sched.sv
// Periodic poll scheduler for the N64 controller reader: issues polls, tracks presence, publishes
// the latched controller word and press events. Define N64_DEBOUNCE_EN for two-capture agreement.
module n64_poll_sched #(
    parameter int unsigned POLL_CYCLES    = 66667,
    parameter int unsigned TIMEOUT_CYCLES = 2000,
    parameter int unsigned MAX_FAILS      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        poll_start,
    input  logic        rd_done,
    input  logic [31:0] rd_state,
    output logic [31:0] state_out,
    output logic        state_valid,
    output logic        ctrl_present,
    output logic [31:0] pressed,
    output logic [3:0]  fail_cnt
);

    localparam int unsigned CntW = $clog2(POLL_CYCLES);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWait,
        StSuccess,
        StFail
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [31:0]       cap_q, cap_d;
    logic [31:0]       state_out_q, state_out_d;
    logic              state_valid_q, state_valid_d;
    logic              present_q, present_d;
    logic [31:0]       pressed_q, pressed_d;
    logic [3:0]        fail_cnt_q, fail_cnt_d;
    logic              wrap;
    logic              upd;
    logic [3:0]        fail_inc;
`ifdef N64_DEBOUNCE_EN
    logic [31:0]       prev_q, prev_d;
    logic              prev_vld_q, prev_vld_d;
`endif

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        tmo_d         = tmo_q;
        cap_d         = cap_q;
        state_out_d   = state_out_q;
        state_valid_d = state_valid_q;
        present_d     = present_q;
        pressed_d     = '0;
        fail_cnt_d    = fail_cnt_q;
        upd           = 1'b0;
        fail_inc      = (fail_cnt_q == 4'(MAX_FAILS)) ? fail_cnt_q : fail_cnt_q + 4'd1;
`ifdef N64_DEBOUNCE_EN
        prev_d        = prev_q;
        prev_vld_d    = prev_vld_q;
`endif

        wrap      = (cnt_q == CntW'(POLL_CYCLES - 1));
        cnt_d     = wrap ? '0 : cnt_q + CntW'(1);
        // A wrap while busy is held until the FSM returns to idle; only one poll is ever held.
        pending_d = pending_q | wrap;

        case (state_q)
            StIdle: begin
                if (pending_q || wrap) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                pending_d = wrap;
                tmo_d     = TmoW'(TIMEOUT_CYCLES - 1);
                state_d   = StWait;
            end
            StWait: begin
                // rd_done takes priority over expiry in the same cycle.
                if (rd_done) begin
                    cap_d   = rd_state;
                    state_d = StSuccess;
                end else if (tmo_q == '0) begin
                    state_d = StFail;
                end else begin
                    tmo_d = tmo_q - TmoW'(1);
                end
            end
            StSuccess: begin
                fail_cnt_d = '0;
                present_d  = 1'b1;
                state_d    = StIdle;
`ifdef N64_DEBOUNCE_EN
                upd        = prev_vld_q && (prev_q == cap_q);
                prev_d     = cap_q;
                prev_vld_d = 1'b1;
`else
                upd        = 1'b1;
`endif
                if (upd) begin
                    state_out_d   = cap_q;
                    state_valid_d = 1'b1;
                    pressed_d     = state_valid_q ? (cap_q & ~state_out_q) : '0;
                end
            end
            StFail: begin
                fail_cnt_d = fail_inc;
                state_d    = StIdle;
                if (fail_inc == 4'(MAX_FAILS)) begin
                    present_d     = 1'b0;
                    state_valid_d = 1'b0;
                    state_out_d   = '0;
`ifdef N64_DEBOUNCE_EN
                    prev_d        = '0;
                    prev_vld_d    = 1'b0;
`endif
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            pending_q     <= 1'b0;
            tmo_q         <= '0;
            cap_q         <= '0;
            state_out_q   <= '0;
            state_valid_q <= 1'b0;
            present_q     <= 1'b0;
            pressed_q     <= '0;
            fail_cnt_q    <= '0;
`ifdef N64_DEBOUNCE_EN
            prev_q        <= '0;
            prev_vld_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            tmo_q         <= tmo_d;
            cap_q         <= cap_d;
            state_out_q   <= state_out_d;
            state_valid_q <= state_valid_d;
            present_q     <= present_d;
            pressed_q     <= pressed_d;
            fail_cnt_q    <= fail_cnt_d;
`ifdef N64_DEBOUNCE_EN
            prev_q        <= prev_d;
            prev_vld_q    <= prev_vld_d;
`endif
        end
    end

    assign poll_start   = (state_q == StStart);
    assign state_out    = state_out_q;
    assign state_valid  = state_valid_q;
    assign ctrl_present = present_q;
    assign pressed      = pressed_q;
    assign fail_cnt     = fail_cnt_q;

endmodule

// File: tb/tb_n64_poll_sched.sv
// Self-checking bench for n64_poll_sched with a per-transaction behavioural reference model.
module tb_n64_poll_sched;

    localparam int unsigned PollCycles    = 100;
    localparam int unsigned TimeoutCycles = 20;
    localparam int unsigned MaxFails      = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_done = 1'b0;
    logic [31:0] rd_state = '0;
    logic        poll_start;
    logic [31:0] state_out;
    logic        state_valid;
    logic        ctrl_present;
    logic [31:0] pressed;
    logic [3:0]  fail_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_poll = -1;
    logic [31:0] last_word = '0;

    // Reference model: state of the scheduler's outputs after each completed poll.
    logic [31:0] m_state, m_pressed, m_prev;
    logic        m_valid, m_present, m_prev_vld;
    int          m_fail;

    n64_poll_sched #(
        .POLL_CYCLES   (PollCycles),
        .TIMEOUT_CYCLES(TimeoutCycles),
        .MAX_FAILS     (MaxFails)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .poll_start  (poll_start),
        .rd_done     (rd_done),
        .rd_state    (rd_state),
        .state_out   (state_out),
        .state_valid (state_valid),
        .ctrl_present(ctrl_present),
        .pressed     (pressed),
        .fail_cnt    (fail_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_state = '0; m_pressed = '0; m_prev = '0;
        m_valid = 1'b0; m_present = 1'b0; m_prev_vld = 1'b0; m_fail = 0;
    endtask

    task automatic model_success(input logic [31:0] w);
        bit agree;
`ifdef N64_DEBOUNCE_EN
        agree = m_prev_vld && (m_prev == w);
        m_prev = w;
        m_prev_vld = 1'b1;
`else
        agree = 1'b1;
`endif
        m_pressed = '0;
        if (agree) begin
            if (m_valid) m_pressed = w & ~m_state;
            m_state = w;
            m_valid = 1'b1;
        end
        m_fail = 0;
        m_present = 1'b1;
    endtask

    task automatic model_fail();
        m_pressed = '0;
        m_fail = (m_fail + 1 > int'(MaxFails)) ? int'(MaxFails) : m_fail + 1;
        if (m_fail == int'(MaxFails)) begin
            m_present = 1'b0; m_valid = 1'b0; m_state = '0;
            m_prev = '0; m_prev_vld = 1'b0;
        end
    endtask

    task automatic wait_poll(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 250 && !seen; i++) begin
            step();
            if (poll_start === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL poll_wait: poll_start=0 for 250 cycles, required a pulse");
        end else if (last_poll >= 0) begin
            checks++;
            if (cyc - last_poll != int'(PollCycles)) begin
                failures++;
                $display("FAIL poll_interval: got %0d cycles, required %0d", cyc - last_poll,
                         PollCycles);
            end
        end
        last_poll = cyc;
    endtask

    // One poll: answer on WAIT cycle `offset` (1..TimeoutCycles) or let it time out.
    task automatic do_poll(input bit respond, input int offset, input logic [31:0] word,
                           input string tag);
        bit seen;
        wait_poll(seen);
        if (!seen) return;
        step();
        if (respond) begin
            for (int k = 1; k < offset; k++) step();
            rd_done = 1'b1;
            rd_state = word;
            step();
            rd_done = 1'b0;
            rd_state = $urandom();
            step();
            model_success(word);
            last_word = word;
        end else begin
            for (int k = 0; k < int'(TimeoutCycles); k++) step();
            step();
            model_fail();
        end
        checks += 5;
        if (state_out !== m_state) begin
            failures++;
            $display("FAIL %s state_out: got %h required %h", tag, state_out, m_state);
        end
        if (pressed !== m_pressed) begin
            failures++;
            $display("FAIL %s pressed: got %h required %h", tag, pressed, m_pressed);
        end
        if (state_valid !== m_valid) begin
            failures++;
            $display("FAIL %s state_valid: got %b required %b", tag, state_valid, m_valid);
        end
        if (ctrl_present !== m_present) begin
            failures++;
            $display("FAIL %s ctrl_present: got %b required %b", tag, ctrl_present, m_present);
        end
        if (fail_cnt !== 4'(m_fail)) begin
            failures++;
            $display("FAIL %s fail_cnt: got %0d required %0d", tag, fail_cnt, m_fail);
        end
        step();
        checks++;
        if (pressed !== 32'h0) begin
            failures++;
            $display("FAIL %s pressed_pulse: got %h one cycle later, required 0", tag, pressed);
        end
    endtask

    task automatic test_reset();
        int exp_fail;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        model_reset();
        checks += 3;
        if ({state_out, pressed} !== 64'h0) begin
            failures++;
            $display("FAIL reset_words: got %h/%h required 0/0", state_out, pressed);
        end
        if ({poll_start, state_valid, ctrl_present} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got %b required 000",
                     {poll_start, state_valid, ctrl_present});
        end
        if (fail_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_fail_cnt: got %0d required 0", fail_cnt);
        end
        for (int n = 1; n <= 350; n++) begin
            step();
            checks += 2;
            if (poll_start !== (n % int'(PollCycles) == 0)) begin
                failures++;
                $display("FAIL idle_poll_start cycle %0d: got %b required %b", n, poll_start,
                         n % int'(PollCycles) == 0);
            end
            if ({ctrl_present, state_valid} !== 2'b00) begin
                failures++;
                $display("FAIL idle_present cycle %0d: got %b required 00", n,
                         {ctrl_present, state_valid});
            end
            if (n % int'(PollCycles) == 0) last_poll = cyc;
            if (n % int'(PollCycles) == 50) begin
                exp_fail = n / int'(PollCycles);
                checks++;
                if (fail_cnt !== 4'(exp_fail)) begin
                    failures++;
                    $display("FAIL idle_fail_cnt cycle %0d: got %0d required %0d", n, fail_cnt,
                             exp_fail);
                end
            end
        end
        m_fail = int'(MaxFails);
    endtask

    task automatic test_first_success();
        do_poll(1'b1, 5, 32'h8000_0000, "first_success");
    endtask

    task automatic test_press_event();
        do_poll(1'b1, int'($urandom_range(1, TimeoutCycles)), 32'h8800_0000, "press_event");
    endtask

    task automatic test_fail_clear();
        for (int i = 0; i < 3; i++) do_poll(1'b0, 0, '0, "fail_clear");
        do_poll(1'b1, int'($urandom_range(1, TimeoutCycles)), $urandom(), "post_fail_success");
    endtask

    task automatic test_timeout_boundary();
        logic [31:0] junk;
        do_poll(1'b0, 0, '0, "pre_boundary_fail");
        do_poll(1'b1, int'(TimeoutCycles), $urandom(), "boundary_success");
        junk = $urandom();
        rd_done = 1'b1;
        rd_state = junk;
        step();
        rd_done = 1'b0;
        step();
        step();
        checks += 3;
        if (state_out !== m_state) begin
            failures++;
            $display("FAIL spurious state_out: got %h required %h", state_out, m_state);
        end
        if (pressed !== 32'h0) begin
            failures++;
            $display("FAIL spurious pressed: got %h required 0", pressed);
        end
        if (fail_cnt !== 4'(m_fail)) begin
            failures++;
            $display("FAIL spurious fail_cnt: got %0d required %0d", fail_cnt, m_fail);
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        int r;
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 2));
            if (r == 0) w = $urandom();
            else if (r == 1) w = last_word ^ (32'h1 << $urandom_range(0, 31));
            else w = last_word;
            do_poll($urandom_range(0, 3) != 0, int'($urandom_range(1, TimeoutCycles)), w,
                    "random");
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        int n;
        wait_poll(seen);
        if (!seen) return;
        step();
        step();
        step();
        rd_done = 1'b1;
        rd_state = $urandom();
        rst_n = 1'b0;
        step();
        rd_done = 1'b0;
        rst_n = 1'b1;
        model_reset();
        checks += 2;
        if ({state_out, pressed, fail_cnt} !== 68'h0) begin
            failures++;
            $display("FAIL midreset_words: got %h/%h/%0d required 0/0/0", state_out, pressed,
                     fail_cnt);
        end
        if ({poll_start, state_valid, ctrl_present} !== 3'b000) begin
            failures++;
            $display("FAIL midreset_flags: got %b required 000",
                     {poll_start, state_valid, ctrl_present});
        end
        n = 0;
        seen = 1'b0;
        while (n < 150 && !seen) begin
            step();
            n++;
            if (poll_start === 1'b1) seen = 1'b1;
        end
        checks++;
        if (n != int'(PollCycles) || !seen) begin
            failures++;
            $display("FAIL midreset_first_poll: got cycle %0d (seen=%b) required %0d", n, seen,
                     PollCycles);
        end
        last_poll = cyc;
        step();
        for (int k = 0; k < int'(TimeoutCycles); k++) step();
        step();
        model_fail();
        checks++;
        if (fail_cnt !== 4'(m_fail)) begin
            failures++;
            $display("FAIL midreset_fail_cnt: got %0d required %0d", fail_cnt, m_fail);
        end
        do_poll(1'b1, 3, 32'h0000_00ff, "midreset_success");
    endtask

    task automatic test_debounce();
        do_poll(1'b1, 2, 32'h1234_0000, "debounce_a");
        do_poll(1'b1, 4, 32'h0000_5678, "debounce_b1");
        do_poll(1'b1, 6, 32'h0000_5678, "debounce_b2");
        checks++;
        if (state_out !== 32'h0000_5678) begin
            failures++;
            $display("FAIL debounce_final: got %h required 00005678", state_out);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_success();
        test_press_event();
        test_fail_clear();
        test_timeout_boundary();
        test_random();
        test_reset_mid_wait();
        test_debounce();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
